snes_ctrlr_if: RTL and testbench

Serial game-pad front end that produces the controller read data consumed by the memory controller's peripheral window (0xFFF0–0xFFF3). Periodically latches and shifts in four SNES-style pads over a shared latch/clock pair and four data lines. Holds the last complete 16-bit sample per pad, and returns the word selected by `addr_ctrlr` on `dout` for CPU loads.

---
 rtl/snes_ctrlr_if_pkg.sv | 26 ++
 rtl/ctrlr_timebase.sv | 23 ++
 rtl/snes_ctrlr_if.sv | 137 +++++++++++++
 tb/tb_snes_ctrlr_if.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/snes_ctrlr_if_pkg.sv
// Shared constants for the SNES pad front end: data width, button bit positions, scan FSM states.
package snes_ctrlr_if_pkg;
   localparam int DATAWIDTH = 16;
   localparam int NUM_PADS  = 4;

   localparam int CTRLR_B      = 0;
   localparam int CTRLR_Y      = 1;
   localparam int CTRLR_SELECT = 2;
   localparam int CTRLR_START  = 3;
   localparam int CTRLR_UP     = 4;
   localparam int CTRLR_DOWN   = 5;
   localparam int CTRLR_LEFT   = 6;
   localparam int CTRLR_RIGHT  = 7;
   localparam int CTRLR_A      = 8;
   localparam int CTRLR_X      = 9;
   localparam int CTRLR_L      = 10;
   localparam int CTRLR_R      = 11;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LATCH  = 3'd1,
      LOW    = 3'd2,
      HIGH   = 3'd3,
      COMMIT = 3'd4
   } ctrlr_state_t;
endpackage

// File: rtl/ctrlr_timebase.sv
// CLK_DIV divider: o_tick marks the last cycle of each CLK_DIV-long phase.
// i_clr restarts the count so every FSM state begins on a fresh phase.
module ctrlr_timebase #(
   parameter int CLK_DIV = 300
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clr,
   output logic o_tick
);
   localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr)     r_cnt <= '0;
      else if (r_cnt == LAST) r_cnt <= '0;
      else                    r_cnt <= r_cnt + CW'(1);
   end

   assign o_tick = (r_cnt == LAST);
endmodule

// File: rtl/snes_ctrlr_if.sv
// Four-pad SNES serial scanner; holds the last complete sample per pad for CPU reads.
// Optional SNES_CTRLR_STICKY_EN: commits OR into the output words, a read reloads the last sample.
module snes_ctrlr_if
   import snes_ctrlr_if_pkg::*;
#(
   parameter int CLK_DIV     = 300,
   parameter int POLL_PERIOD = 833333
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ctrlr_re,
   input  logic [1:0]           addr_ctrlr,
   output logic [DATAWIDTH-1:0] dout,
   output logic                 pad_latch,
   output logic                 pad_clk,
   input  logic [NUM_PADS-1:0]  pad_data
);
   localparam int PW = $clog2(POLL_PERIOD);

   ctrlr_state_t                          r_state;
   logic [PW-1:0]                         r_poll;
   logic [3:0]                            r_bit;
   logic                                  r_half;
   logic                                  r_latch;
   logic                                  r_pclk;
   logic [NUM_PADS-1:0][DATAWIDTH-1:0]    r_shift;
   logic [NUM_PADS-1:0][DATAWIDTH-1:0]    r_out;
   logic                                  w_poll_wrap;
   logic                                  w_tick;
   logic                                  w_chg;

   assign w_poll_wrap = (r_poll == PW'(POLL_PERIOD - 1));

   // Any state change restarts the phase divider.
   always_comb begin
      w_chg = 1'b0;
      case (r_state)
         IDLE:     w_chg = w_poll_wrap;
         LATCH:    w_chg = w_tick && r_half;
         LOW,
         HIGH:     w_chg = w_tick;
         default:  w_chg = 1'b1;
      endcase
   end

   ctrlr_timebase #(.CLK_DIV(CLK_DIV)) u_tb (
      .i_clk  (clk),
      .i_rst  (rst),
      .i_clr  (w_chg),
      .o_tick (w_tick)
   );

   // Poll counter free-runs through the scan so the poll period stays exact.
   always_ff @(posedge clk) begin
      if (rst || w_poll_wrap) r_poll <= '0;
      else                    r_poll <= r_poll + PW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_bit   <= '0;
         r_half  <= 1'b0;
         r_latch <= 1'b0;
         r_pclk  <= 1'b1;
         r_shift <= '0;
      end else begin
         case (r_state)
            IDLE: if (w_poll_wrap) begin
               r_state <= LATCH;
               r_latch <= 1'b1;
               r_half  <= 1'b0;
            end
            LATCH: if (w_tick) begin
               if (r_half) begin
                  r_state <= LOW;
                  r_latch <= 1'b0;
                  r_pclk  <= 1'b0;
                  r_bit   <= '0;
               end else begin
                  r_half <= 1'b1;
               end
            end
            LOW: if (w_tick) begin
               for (int p = 0; p < NUM_PADS; p++)
                  r_shift[p][r_bit] <= ~pad_data[p];
               r_state <= HIGH;
               r_pclk  <= 1'b1;
            end
            HIGH: if (w_tick) begin
               if (r_bit == 4'd15) begin
                  r_state <= COMMIT;
               end else begin
                  r_bit   <= r_bit + 4'd1;
                  r_state <= LOW;
                  r_pclk  <= 1'b0;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

`ifdef SNES_CTRLR_STICKY_EN
   logic [NUM_PADS-1:0][DATAWIDTH-1:0] r_last;

   // A read in the commit cycle takes the fresh sample alone, so nothing is lost or repeated.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out  <= '0;
         r_last <= '0;
      end else begin
         for (int p = 0; p < NUM_PADS; p++) begin
            if (r_state == COMMIT) begin
               r_last[p] <= r_shift[p];
               if (ctrlr_re && (addr_ctrlr == 2'(p))) r_out[p] <= r_shift[p];
               else                                   r_out[p] <= r_out[p] | r_shift[p];
            end else if (ctrlr_re && (addr_ctrlr == 2'(p))) begin
               r_out[p] <= r_last[p];
            end
         end
      end
   end
`else
   logic w_unused_re;
   assign w_unused_re = ctrlr_re;

   always_ff @(posedge clk) begin
      if (rst)                    r_out <= '0;
      else if (r_state == COMMIT) r_out <= r_shift;
   end
`endif

   assign dout      = r_out[addr_ctrlr];
   assign pad_latch = r_latch;
   assign pad_clk   = r_pclk;
endmodule

// File: tb/tb_snes_ctrlr_if.sv
// Bench for snes_ctrlr_if: pad models plus a poll-schedule reference model checked every cycle.
// Honours SNES_CTRLR_STICKY_EN in the model when the macro is defined for the build.
module tb_snes_ctrlr_if;
   localparam int D    = 2;
   localparam int P    = 100;
   localparam int SCAN = 34 * D;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ctrlr_re = 1'b0;
   logic [1:0]  addr_ctrlr = 2'd0;
   logic [15:0] dout;
   logic        pad_latch;
   logic        pad_clk;
   logic [3:0]  pad_data;

   always #5 clk = ~clk;

   snes_ctrlr_if #(.CLK_DIV(D), .POLL_PERIOD(P)) dut (
      .clk        (clk),
      .rst        (rst),
      .ctrlr_re   (ctrlr_re),
      .addr_ctrlr (addr_ctrlr),
      .dout       (dout),
      .pad_latch  (pad_latch),
      .pad_clk    (pad_clk),
      .pad_data   (pad_data)
   );

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
      end
   endtask

   // Pads: snapshot buttons on latch, advance one bit per pad_clk rise, active-low data.
   logic [15:0] btn [4];
   logic [15:0] psnap [4];
   int          bitcnt = 16;

   always @(posedge pad_latch or posedge pad_clk) begin
      if (pad_latch === 1'b1) begin
         for (int p = 0; p < 4; p++) psnap[p] = btn[p];
         bitcnt = 0;
      end else if (bitcnt < 16) begin
         bitcnt++;
      end
   end

   always_comb begin
      for (int p = 0; p < 4; p++)
         pad_data[p] = (bitcnt < 16) ? ~psnap[p][bitcnt[3:0]] : 1'b1;
   end

   // Reference model: c = cycles since the first cycle after the reset edge.
   int          c = 0;
   bit          started = 1'b0;
   logic [15:0] exp_out [4];
   logic [15:0] exp_last [4];
   logic [15:0] msnap [4];

   always @(posedge clk) begin
      if (rst) begin
         c = 0;
         started = 1'b1;
         for (int p = 0; p < 4; p++) begin
            exp_out[p] = '0;
            exp_last[p] = '0;
         end
      end else if (started) begin
         if (c >= P && (c % P) == SCAN) begin
            for (int p = 0; p < 4; p++) begin
`ifdef SNES_CTRLR_STICKY_EN
               if (ctrlr_re && addr_ctrlr == 2'(p)) exp_out[p] = msnap[p];
               else                                 exp_out[p] = exp_out[p] | msnap[p];
`else
               exp_out[p] = msnap[p];
`endif
               exp_last[p] = msnap[p];
            end
         end
`ifdef SNES_CTRLR_STICKY_EN
         else if (ctrlr_re) begin
            exp_out[addr_ctrlr] = exp_last[addr_ctrlr];
         end
`endif
         if (((c + 1) % P) == 0)
            for (int p = 0; p < 4; p++) msnap[p] = btn[p];
         c = c + 1;
      end
   end

   int ph;
   logic e_latch, e_pclk;
   always @(negedge clk) begin
      if (started) begin
         ph      = c % P;
         e_latch = (c >= P) && (ph < 2 * D);
         e_pclk  = !((c >= P) && ph >= 2 * D && ph < SCAN && (((ph - 2 * D) / D) % 2) == 0);
         chk("latch", {15'd0, pad_latch}, {15'd0, e_latch});
         chk("pclk",  {15'd0, pad_clk},   {15'd0, e_pclk});
         chk("dout",  dout, exp_out[addr_ctrlr]);
      end
   end

   // Waveform monitor: latch width, poll spacing, pad_clk low pulses in the current scan.
   int   t = 0, t_rise = 0, spacing = 0, lw_run = 0, latch_w = 0;
   int   low_run = 0, pulses = 0, bad_w = 0;
   logic prev_latch = 1'b0, prev_pclk = 1'b1;
   always @(negedge clk) begin
      t++;
      if (pad_latch === 1'b1 && !prev_latch) begin
         spacing = t - t_rise;
         t_rise  = t;
         pulses  = 0;
         bad_w   = 0;
         lw_run  = 0;
         low_run = 0;
      end
      if (pad_latch === 1'b1) lw_run++;
      else if (prev_latch) latch_w = lw_run;
      if (pad_clk === 1'b0) low_run++;
      else if (!prev_pclk) begin
         pulses++;
         if (low_run != D) bad_w++;
         low_run = 0;
      end
      prev_latch = (pad_latch === 1'b1);
      prev_pclk  = (pad_clk !== 1'b0);
   end

   task automatic wait_ph(input int target);
      int n;
      n = 0;
      do begin
         @(posedge clk); #2;
         n++;
      end while (!(c >= P && (c % P) == target) && n < 3 * P);
      if (n >= 3 * P) chk("wait_ph_timeout", 16'(n), 16'(0));
   endtask

   task automatic meas_latch(output int n);
      n = 0;
      while (n < 3 * P) begin
         @(posedge clk); #2;
         n++;
         if (pad_latch === 1'b1) break;
      end
   endtask

   task automatic read_clear();
      for (int a = 0; a < 4; a++) begin
         addr_ctrlr = 2'(a);
         ctrlr_re = 1'b1;
         @(posedge clk); #2;
      end
      ctrlr_re = 1'b0;
   endtask

   task automatic chk_all(input string nm, input logic [15:0] e0, input logic [15:0] e1,
                          input logic [15:0] e2, input logic [15:0] e3);
      logic [15:0] ev [4];
      ev[0] = e0; ev[1] = e1; ev[2] = e2; ev[3] = e3;
      for (int a = 0; a < 4; a++) begin
         addr_ctrlr = 2'(a);
         #1 chk(nm, dout, ev[a]);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   int n;
   initial begin
      for (int p = 0; p < 4; p++) btn[p] = '0;
      btn[0] = 16'h0F31;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      chk("rst_latch", {15'd0, pad_latch}, 16'd0);
      chk("rst_pclk",  {15'd0, pad_clk},   16'd1);
      chk_all("rst_dout", 16'h0, 16'h0, 16'h0, 16'h0);
      addr_ctrlr = 2'd0;
      rst = 1'b0;
      meas_latch(n);
      chk("first_latch", 16'(n), 16'(P));

      // Single pad pattern; pad_clk must show 16 lows of D cycles.
      wait_ph(SCAN + 2);
      chk_all("single", 16'h0F31, 16'h0, 16'h0, 16'h0);
      chk("pulses", 16'(pulses), 16'd16);
      chk("pulse_w", 16'(bad_w), 16'd0);

      btn[0] = 16'hA5A5; btn[1] = 16'h5A5A; btn[2] = 16'hFFFF; btn[3] = 16'h0000;
      wait_ph(SCAN + 2);
      read_clear();
      chk_all("four", 16'hA5A5, 16'h5A5A, 16'hFFFF, 16'h0000);
      chk("latch_w", 16'(latch_w), 16'(2 * D));
      chk("spacing", 16'(spacing), 16'(P));

      // Stability: data flips 1111 -> 2222, addr swept every cycle.
      for (int p = 0; p < 4; p++) btn[p] = 16'h1111;
      wait_ph(SCAN + 2);
      read_clear();
      for (int p = 0; p < 4; p++) btn[p] = 16'h2222;
      for (int k = 0; k < 2 * P; k++) begin
         addr_ctrlr = 2'($urandom);
         @(posedge clk); #2;
         if (c % P == SCAN) break;
      end
      addr_ctrlr = 2'd1;
      #1 chk("stab_pre", dout, 16'h1111);
      @(posedge clk); #2;
`ifdef SNES_CTRLR_STICKY_EN
      chk("stab_post", dout, 16'h3333);
`else
      chk("stab_post", dout, 16'h2222);
`endif

      for (int k = 0; k < 800; k++) begin
         addr_ctrlr = 2'($urandom);
         ctrlr_re = ($urandom_range(7) == 0);
         if ($urandom_range(15) == 0) btn[$urandom_range(3)] = 16'($urandom);
         @(posedge clk); #2;
      end
      ctrlr_re = 1'b0;

      // Reset in the LOW phase of bit 7.
      wait_ph(2 * D + 14 * D);
      chk("low7", {15'd0, pad_clk}, 16'd0);
      rst = 1'b1;
      for (int p = 0; p < 4; p++) btn[p] = '0;
      btn[0] = 16'h0008;
      @(posedge clk); #2;
      chk("mid_pclk",  {15'd0, pad_clk},   16'd1);
      chk("mid_latch", {15'd0, pad_latch}, 16'd0);
      chk_all("mid_dout", 16'h0, 16'h0, 16'h0, 16'h0);
      rst = 1'b0;
      addr_ctrlr = 2'd0;
      meas_latch(n);
      chk("relatch", 16'(n), 16'(P));

      // START pressed for one poll, then released.
      wait_ph(SCAN + 1);
      chk("start_on", dout, 16'h0008);
      btn[0] = 16'h0000;
      wait_ph(SCAN + 1);
`ifdef SNES_CTRLR_STICKY_EN
      chk("start_held", dout, 16'h0008);
`else
      chk("start_held", dout, 16'h0000);
`endif
      ctrlr_re = 1'b1;
      @(posedge clk); #2;
      ctrlr_re = 1'b0;
      #1 chk("start_read", dout, 16'h0000);
      repeat (3) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
